// File: rtl/usb_seq_pkg.sv
// usb_seq_pkg
// Shared types and constants for the Fomu USB soft-connect sequencer.
//   conn_state_t   : sequencer states DISC / SETTLE / CONN
//   pad_ctrl_t     : bundle of the registered pad/status controls
//   DEF_*          : default cycle counts for a 48 MHz clock
//   state_outputs(): pad/status controls that belong to a given state
package usb_seq_pkg;

  typedef enum logic [1:0] {
    DISC   = 2'd0,
    SETTLE = 2'd1,
    CONN   = 2'd2
  } conn_state_t;

  typedef struct packed {
    logic oe;
    logic pu;
    logic busy;
    logic connected;
  } pad_ctrl_t;

  // 100 ms forced disconnect, 10 us settle, 2.5 us SE0 for a host bus reset
  localparam int DEF_DISC_CYCLES    = 4800000;
  localparam int DEF_SETTLE_CYCLES  = 480;
  localparam int DEF_BUS_RST_CYCLES = 120;
  localparam int DEF_CNT_W          = 23;

  // DISC drives SE0 with the pull-up off, SETTLE floats the pins with the
  // pull-up still off, CONN enables the pull-up so the host sees a device.
  function automatic pad_ctrl_t state_outputs(input conn_state_t s);
    pad_ctrl_t c;
    c = '{oe: 1'b1, pu: 1'b0, busy: 1'b1, connected: 1'b0};
    case (s)
      DISC:    c = '{oe: 1'b1, pu: 1'b0, busy: 1'b1, connected: 1'b0};
      SETTLE:  c = '{oe: 1'b0, pu: 1'b0, busy: 1'b1, connected: 1'b0};
      CONN:    c = '{oe: 1'b0, pu: 1'b1, busy: 1'b0, connected: 1'b1};
      default: c = '{oe: 1'b1, pu: 1'b0, busy: 1'b1, connected: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/usb_se0_detect.sv
// usb_se0_detect
// Detects a host-issued bus reset (sustained SE0) while the device is
// connected. Only instantiated when USB_BUS_RESET_EN is defined.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   dp_async   : D+ pad input, not synchronised to clk
//   dn_async   : D- pad input, not synchronised to clk
//   enable     : high while the sequencer is in CONN
//   bus_reset  : one-cycle pulse once SE0 has lasted BUS_RST_CYCLES cycles
module usb_se0_detect #(
  parameter int BUS_RST_CYCLES = 120,
  parameter int CNT_W          = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic dp_async,
  input  logic dn_async,
  input  logic enable,
  output logic bus_reset
);

  localparam logic [CNT_W-1:0] SE0_LAST = CNT_W'(BUS_RST_CYCLES - 1);

  logic dp_meta, dp_sync;
  logic dn_meta, dn_sync;
  logic se0;
  logic armed;
  logic [CNT_W-1:0] se0_cnt;

  // Two-flop synchronisers. They reset to 1 (idle J-ish level) so that
  // reset itself can never look like the start of an SE0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_meta <= 1'b1;
      dp_sync <= 1'b1;
      dn_meta <= 1'b1;
      dn_sync <= 1'b1;
    end else begin
      dp_meta <= dp_async;
      dp_sync <= dp_meta;
      dn_meta <= dn_async;
      dn_sync <= dn_meta;
    end
  end

  // SE0 only counts while connected; in DISC/SETTLE the pins are either
  // driven low by us or floating, so a low level there means nothing.
  assign se0 = enable & ~dp_sync & ~dn_sync;

  // se0_cnt saturates at the terminal value; the pulse fires once per SE0
  // episode and detection re-arms only after a non-SE0 cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      se0_cnt   <= '0;
      armed     <= 1'b1;
      bus_reset <= 1'b0;
    end else begin
      bus_reset <= 1'b0;
      if (!se0) begin
        se0_cnt <= '0;
        armed   <= 1'b1;
      end else if (se0_cnt == SE0_LAST) begin
        if (armed) begin
          bus_reset <= 1'b1;
          armed     <= 1'b0;
        end
      end else begin
        se0_cnt <= se0_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_connect_seq.sv
// usb_connect_seq
// Fomu USB soft-connect sequencer. After reset or a disc_req it forces a
// host-visible disconnect (SE0 driven, pull-up off), releases the pins for a
// settle interval, then enables the D+ pull-up so the host enumerates.
// Optional feature macro: USB_BUS_RESET_EN (host bus-reset detection).
// Ports:
//   clk, rst            : 48 MHz clock, asynchronous active-high reset
//   disc_req            : single-cycle request to restart the sequence
//   usb_dp, usb_dn      : pad output values (always 0)
//   usb_oe              : pad output enable (high only in DISC)
//   usb_dp_pu           : D+ 1.5k pull-up enable (high only in CONN)
//   busy, connected     : status, busy outside CONN, connected in CONN
//   usb_dp_i, usb_dn_i  : asynchronous pad inputs (bus-reset detection)
//   bus_reset           : one-cycle pulse on a detected host bus reset
module usb_connect_seq
  import usb_seq_pkg::*;
#(
  parameter int DISC_CYCLES    = DEF_DISC_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int BUS_RST_CYCLES = DEF_BUS_RST_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic disc_req,
  output logic usb_dp,
  output logic usb_dn,
  output logic usb_oe,
  output logic usb_dp_pu,
  output logic busy,
  output logic connected,
  input  logic usb_dp_i,
  input  logic usb_dn_i,
  output logic bus_reset
);

  localparam logic [CNT_W-1:0] DISC_LAST   = CNT_W'(DISC_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  conn_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  pad_ctrl_t        ctrl_nxt;

  // Pad values are never driven high; only the enable and pull-up move.
  assign usb_dp = 1'b0;
  assign usb_dn = 1'b0;

  // State register. The pad/status outputs are registered alongside the
  // state from the next-state decode, so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DISC;
      cnt       <= '0;
      usb_oe    <= 1'b1;
      usb_dp_pu <= 1'b0;
      busy      <= 1'b1;
      connected <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      usb_oe    <= ctrl_nxt.oe;
      usb_dp_pu <= ctrl_nxt.pu;
      busy      <= ctrl_nxt.busy;
      connected <= ctrl_nxt.connected;
    end
  end

  // Next-state decode. disc_req wins over everything, including a terminal
  // count in the same cycle, so holding it keeps us parked in DISC, cnt=0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (disc_req) begin
      state_nxt = DISC;
      cnt_nxt   = '0;
    end else begin
      case (state)
        DISC: begin
          if (cnt == DISC_LAST) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = CONN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        CONN: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = DISC;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode for the state being entered.
  always_comb begin
    ctrl_nxt = state_outputs(state_nxt);
  end

`ifdef USB_BUS_RESET_EN
  usb_se0_detect #(
    .BUS_RST_CYCLES (BUS_RST_CYCLES),
    .CNT_W          (CNT_W)
  ) u_se0_detect (
    .clk       (clk),
    .rst       (rst),
    .dp_async  (usb_dp_i),
    .dn_async  (usb_dn_i),
    .enable    (connected),
    .bus_reset (bus_reset)
  );
`else
  // Detection disabled: the pad inputs stay on the port list but go nowhere.
  logic unused_bus_reset_inputs;
  localparam logic [31:0] UNUSED_BUS_RST = 32'(BUS_RST_CYCLES);
  assign unused_bus_reset_inputs = usb_dp_i ^ usb_dn_i ^ UNUSED_BUS_RST[0];
  assign bus_reset = 1'b0;
`endif

endmodule

// File: doc/usb_connect_seq.md
Name: usb_connect_seq

Overview:
Sequences the Fomu USB soft-connect. After reset, or on request, it forces a host-visible disconnect: SE0 is driven and the D+ pull-up is off. It then releases the pins, waits a settle interval, and enables the D+ pull-up so the host enumerates.
It sits directly upstream of the USB pad drivers. It owns usb_dp/usb_dn/usb_dp_pu in place of the permanent tie-low disconnect stub, and it feeds the pad output-enables and values.

Parameters:
DISC_CYCLES, 4800000, cycles of forced disconnect (100 ms at 48 MHz); must be >=1
SETTLE_CYCLES, 480, cycles with pins released and pull-up still off (10 us at 48 MHz); must be >=1
BUS_RST_CYCLES, 120, consecutive SE0 cycles that qualify as a host bus reset (2.5 us); used only with USB_BUS_RESET_EN
CNT_W, 23, counter width; 2**CNT_W > max(DISC_CYCLES, SETTLE_CYCLES, BUS_RST_CYCLES)

Ports:
clk  input  1  system clock (48 MHz)
rst  input  1  asynchronous, active-high reset
disc_req  input  1  single-cycle request to force a disconnect/reconnect
usb_dp  output  1  D+ output value
usb_dn  output  1  D- output value
usb_oe  output  1  pad output enable for D+/D-
usb_dp_pu  output  1  D+ 1.5k pull-up enable
busy  output  1  high whenever the sequence is not in CONN
connected  output  1  high in CONN (pull-up enabled)
usb_dp_i  input  1  D+ pad input (asynchronous)
usb_dn_i  input  1  D- pad input (asynchronous)
bus_reset  output  1  one-cycle pulse on detected host bus reset

Interface decision: one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- States: DISC, SETTLE, CONN. Counter cnt[CNT_W-1:0]. All outputs are registered and change on the same edge as the state.
- Reset (rst=1, async):
  - state=DISC, cnt=0
  - usb_oe=1, usb_dp=0, usb_dn=0, usb_dp_pu=0
  - busy=1, connected=0, bus_reset=0
- usb_dp and usb_dn are 0 in every state. Only usb_oe and usb_dp_pu vary.
- DISC:
  - Outputs: oe=1, pu=0. cnt increments each cycle.
  - When cnt==DISC_CYCLES-1: go to SETTLE and clear cnt. DISC therefore lasts exactly DISC_CYCLES cycles.
- SETTLE:
  - Outputs: oe=0, pu=0. cnt increments.
  - When cnt==SETTLE_CYCLES-1: go to CONN and clear cnt.
- CONN:
  - Outputs: oe=0, pu=1, connected=1, busy=0. cnt is held at 0.
- disc_req=1 in any state, at any edge: next state is DISC with cnt=0.
  - In DISC or SETTLE this restarts the full sequence (the disconnect is extended).
  - disc_req has priority over a count-terminal transition in the same cycle.
- Latency:
  - First release of rst: connected rises exactly DISC_CYCLES+SETTLE_CYCLES clock edges after the first edge with rst low.
  - disc_req sampled high at edge N: outputs show the DISC values after edge N.
- disc_req held high for multiple cycles behaves as repeated requests. The sequence stays in DISC with cnt=0 until the request drops.
- Counter comparisons are unsigned and at full CNT_W width. cnt never exceeds the terminal value of the current state, so it never wraps.

Optional Feature:
Macro: USB_BUS_RESET_EN.
- Defined:
  - usb_dp_i and usb_dn_i pass through 2-flop synchronisers, reset to 1.
  - In CONN, a se0_cnt counts consecutive cycles with both synchronised inputs low.
  - When se0_cnt reaches BUS_RST_CYCLES-1, bus_reset pulses for one cycle and detection disarms.
  - Detection re-arms after any non-SE0 cycle. se0_cnt clears on non-SE0 and outside CONN.
  - SE0 seen in DISC or SETTLE (self-driven or released) never produces a pulse.
- Not defined:
  - Inputs are ignored and bus_reset is tied 0.
  - No synchroniser or se0_cnt logic is generated. Ports remain present.

Decomposition:
- Package usb_seq_pkg:
  - state enum (DISC, SETTLE, CONN)
  - default cycle constants for 48 MHz (100 ms, 10 us, 2.5 us)
- One natural sub-module: usb_se0_detect. It contains the synchronisers, se0_cnt and the arm/pulse logic, and is instantiated only under USB_BUS_RESET_EN.

Test Plan:
Bench parameters are DISC_CYCLES=10, SETTLE_CYCLES=4, BUS_RST_CYCLES=5, CNT_W=8.
1. Release rst -> oe=1/pu=0 for 10 cycles, then oe=0/pu=0 for 4 cycles, then pu=1, connected=1, busy=0 on edge 14. usb_dp/usb_dn stay 0 throughout.
2. In CONN, pulse disc_req -> next cycle oe=1, pu=0, busy=1; reconnect after a further 10+4 cycles.
3. disc_req in SETTLE cycle 2, and separately in the same cycle as the DISC terminal count -> state DISC with cnt=0; full 10+4 restart.
4. Assert rst asynchronously mid-SETTLE, off a clock edge -> outputs return to reset values immediately, without waiting for an edge.
5. (USB_BUS_RESET_EN) In CONN, hold dp_i=dn_i=0 for 20 cycles -> exactly one bus_reset pulse, 2 sync cycles + 5 cycles after SE0 onset. Release, then SE0 again -> a second pulse.
6. (USB_BUS_RESET_EN) SE0 held during DISC/SETTLE, and SE0 lasting 4 cycles in CONN -> no bus_reset. Without the macro -> bus_reset is always 0.
